// File: rtl/median_pivot_ctrl.sv
// median_pivot_ctrl: quickselect sequencer for the median-filter fill stage.
// Each pass hands the fill stage a pivot and a partition size, then reads
// back the partition counts and extremes to pick the partition holding the
// target rank and to derive the next pivot.
// Optional feature macro: MEDIAN_PASS_LIMIT_EN (pass counter + med_err).
module median_pivot_ctrl #(
  parameter int BUFF_SIZE     = 32,
  parameter int BUFF_SIZE_BIT = $clog2(BUFF_SIZE) + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [BUFF_SIZE_BIT-1:0] in_size,
  input  logic                     up_next,
  input  logic [BUFF_SIZE_BIT-1:0] lower_size,
  input  logic [BUFF_SIZE_BIT-1:0] equal_size,
  input  logic [BUFF_SIZE_BIT-1:0] larger_size,
  input  logic [7:0]               min_lower,
  input  logic [7:0]               max_lower,
  input  logic [7:0]               min_larger,
  input  logic [7:0]               max_larger,
  output logic [7:0]               pivot_samp,
  output logic [BUFF_SIZE_BIT-1:0] buff_size_samp,
  output logic                     control_sampled,
  output logic                     sending,
  output logic [1:0]               part_sel,
  output logic [7:0]               median,
  output logic                     med_valid,
`ifdef MEDIAN_PASS_LIMIT_EN
  output logic                     med_err,
`endif
  input  logic                     med_ack
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ARM       = 3'd1,
    WAIT_FILL = 3'd2,
    DECIDE    = 3'd3,
    DONE      = 3'd4
  } state_t;

  localparam logic [BUFF_SIZE_BIT-1:0] ONE_SZ   = BUFF_SIZE_BIT'(1);
  localparam logic [7:0]               PIV_INIT = 8'd128;

  // Ceiling average at 9 bits: result is strictly above a and at most b when a < b.
  function automatic logic [7:0] ceil_avg(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b} + 9'd1;
    return s[8:1];
  endfunction

  state_t state, state_nxt;

  logic [BUFF_SIZE_BIT-1:0] k_q, k_nxt;
  logic [BUFF_SIZE_BIT-1:0] l_q, e_q, g_q;
  logic [7:0]               minl_q, maxl_q, ming_q, maxg_q;

  logic [7:0]               pivot_nxt;
  logic [BUFF_SIZE_BIT-1:0] size_nxt;
  logic [1:0]               sel_nxt;
  logic [7:0]               median_nxt;

  logic [BUFF_SIZE_BIT:0]   le_sum;
  logic [BUFF_SIZE_BIT:0]   k_ext;
  logic [BUFF_SIZE_BIT:0]   k_rem;

`ifdef MEDIAN_PASS_LIMIT_EN
  logic [3:0] pass_cnt, pass_cnt_nxt;
  logic       err_nxt;
`endif

  // L+E is kept one bit wider so the rank comparisons never wrap.
  assign le_sum = {1'b0, l_q} + {1'b0, e_q};
  assign k_ext  = {1'b0, k_q};
  assign k_rem  = k_ext - le_sum;

  // Next-state and next register values; every target defaults to hold.
  always_comb begin
    state_nxt  = state;
    k_nxt      = k_q;
    pivot_nxt  = pivot_samp;
    size_nxt   = buff_size_samp;
    sel_nxt    = part_sel;
    median_nxt = median;
`ifdef MEDIAN_PASS_LIMIT_EN
    pass_cnt_nxt = pass_cnt;
    err_nxt      = med_err;
`endif
    case (state)
      IDLE: begin
        if (start && (in_size != '0)) begin
          state_nxt = ARM;
          k_nxt     = (in_size - ONE_SZ) >> 1;
          pivot_nxt = PIV_INIT;
          size_nxt  = in_size;
          sel_nxt   = 2'b00;
`ifdef MEDIAN_PASS_LIMIT_EN
          pass_cnt_nxt = 4'd1;
`endif
        end
      end
      ARM: begin
        state_nxt = WAIT_FILL;
      end
      WAIT_FILL: begin
        if (up_next) state_nxt = DECIDE;
      end
      DECIDE: begin
        if (k_ext < {1'b0, l_q}) begin
          if (minl_q == maxl_q) begin
            median_nxt = minl_q;
            state_nxt  = DONE;
          end else begin
            sel_nxt   = 2'b01;
            size_nxt  = l_q;
            pivot_nxt = ceil_avg(minl_q, maxl_q);
            state_nxt = ARM;
          end
        end else if (k_ext < le_sum) begin
          median_nxt = pivot_samp;
          state_nxt  = DONE;
        end else begin
          k_nxt = k_rem[BUFF_SIZE_BIT-1:0];
          if (ming_q == maxg_q) begin
            median_nxt = ming_q;
            state_nxt  = DONE;
          end else begin
            sel_nxt   = 2'b10;
            size_nxt  = g_q;
            pivot_nxt = ceil_avg(ming_q, maxg_q);
            state_nxt = ARM;
          end
        end
`ifdef MEDIAN_PASS_LIMIT_EN
        if (state_nxt == ARM) begin
          if (pass_cnt == 4'd9) begin
            state_nxt  = DONE;
            median_nxt = pivot_samp;
            pivot_nxt  = pivot_samp;
            size_nxt   = buff_size_samp;
            sel_nxt    = part_sel;
            err_nxt    = 1'b1;
          end else begin
            pass_cnt_nxt = pass_cnt + 4'd1;
          end
        end
`endif
      end
      DONE: begin
        if (med_ack) begin
          state_nxt = IDLE;
`ifdef MEDIAN_PASS_LIMIT_EN
          err_nxt = 1'b0;
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Registered outputs, rank and captured fill results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pivot_samp      <= PIV_INIT;
      buff_size_samp  <= '0;
      part_sel        <= 2'b00;
      median          <= 8'd0;
      control_sampled <= 1'b0;
      med_valid       <= 1'b0;
      sending         <= 1'b1;
      k_q             <= '0;
      l_q             <= '0;
      e_q             <= '0;
      g_q             <= '0;
      minl_q          <= 8'd0;
      maxl_q          <= 8'd0;
      ming_q          <= 8'd0;
      maxg_q          <= 8'd0;
`ifdef MEDIAN_PASS_LIMIT_EN
      pass_cnt        <= 4'd0;
      med_err         <= 1'b0;
`endif
    end else begin
      pivot_samp      <= pivot_nxt;
      buff_size_samp  <= size_nxt;
      part_sel        <= sel_nxt;
      median          <= median_nxt;
      k_q             <= k_nxt;
      control_sampled <= (state_nxt == ARM);
      med_valid       <= (state_nxt == DONE);
      sending         <= (state_nxt != WAIT_FILL);
      if ((state == WAIT_FILL) && up_next) begin
        l_q    <= lower_size;
        e_q    <= equal_size;
        g_q    <= larger_size;
        minl_q <= min_lower;
        maxl_q <= max_lower;
        ming_q <= min_larger;
        maxg_q <= max_larger;
      end
`ifdef MEDIAN_PASS_LIMIT_EN
      pass_cnt <= pass_cnt_nxt;
      med_err  <= err_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_median_pivot_ctrl.sv
// Directed bench for median_pivot_ctrl; the bench plays the fill stage.
module tb_median_pivot_ctrl;

  localparam int BSB = 6;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic [BSB-1:0] in_size;
  logic           up_next;
  logic [BSB-1:0] lower_size, equal_size, larger_size;
  logic [7:0]     min_lower, max_lower, min_larger, max_larger;
  logic [7:0]     pivot_samp;
  logic [BSB-1:0] buff_size_samp;
  logic           control_sampled;
  logic           sending;
  logic [1:0]     part_sel;
  logic [7:0]     median;
  logic           med_valid;
  logic           med_ack;
`ifdef MEDIAN_PASS_LIMIT_EN
  logic           med_err;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  int cs_cnt   = 0;

  median_pivot_ctrl #(.BUFF_SIZE(32), .BUFF_SIZE_BIT(BSB)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .in_size         (in_size),
    .up_next         (up_next),
    .lower_size      (lower_size),
    .equal_size      (equal_size),
    .larger_size     (larger_size),
    .min_lower       (min_lower),
    .max_lower       (max_lower),
    .min_larger      (min_larger),
    .max_larger      (max_larger),
    .pivot_samp      (pivot_samp),
    .buff_size_samp  (buff_size_samp),
    .control_sampled (control_sampled),
    .sending         (sending),
    .part_sel        (part_sel),
    .median          (median),
    .med_valid       (med_valid),
`ifdef MEDIAN_PASS_LIMIT_EN
    .med_err         (med_err),
`endif
    .med_ack         (med_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pivot"},  int'(pivot_samp), 128);
    chk({tag, "_size"},   int'(buff_size_samp), 0);
    chk({tag, "_sel"},    int'(part_sel), 0);
    chk({tag, "_median"}, int'(median), 0);
    chk({tag, "_cs"},     int'(control_sampled), 0);
    chk({tag, "_valid"},  int'(med_valid), 0);
    chk({tag, "_send"},   int'(sending), 1);
  endtask

  task automatic start_win(input int sz);
    @(negedge clk);
    start   = 1'b1;
    in_size = BSB'(sz);
    cs_cnt  = 0;
    @(negedge clk);
    start   = 1'b0;
  endtask

  // Wait for WAIT_FILL, check the pass setup, then answer with one fill result.
  task automatic do_pass(input int piv, input int sz, input int sel,
                         input int l, input int e, input int g,
                         input int mnl, input int mxl, input int mng, input int mxg);
    int n = 0;
    while (sending && n < 40) begin
      cs_cnt += int'(control_sampled);
      @(negedge clk);
      n++;
    end
    chk("fill_reached", int'(sending), 0);
    chk("pass_pivot", int'(pivot_samp), piv);
    chk("pass_size",  int'(buff_size_samp), sz);
    chk("pass_sel",   int'(part_sel), sel);
    up_next     = 1'b1;
    lower_size  = BSB'(l);
    equal_size  = BSB'(e);
    larger_size = BSB'(g);
    min_lower   = 8'(mnl);
    max_lower   = 8'(mxl);
    min_larger  = 8'(mng);
    max_larger  = 8'(mxg);
    @(negedge clk);
    up_next     = 1'b0;
  endtask

  task automatic wait_result(input int med, input int passes);
    int n = 0;
    while (!med_valid && n < 40) begin
      cs_cnt += int'(control_sampled);
      @(negedge clk);
      n++;
    end
    chk("result_valid", int'(med_valid), 1);
    chk("result_median", int'(median), med);
    chk("result_passes", cs_cnt, passes);
  endtask

  task automatic ack_result();
    med_ack = 1'b1;
    @(negedge clk);
    med_ack = 1'b0;
    chk("ack_valid_low", int'(med_valid), 0);
    chk("ack_sending", int'(sending), 1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; in_size = '0; up_next = 1'b0; med_ack = 1'b0;
    lower_size = '0; equal_size = '0; larger_size = '0;
    min_lower = 8'd0; max_lower = 8'd0; min_larger = 8'd0; max_larger = 8'd0;
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Odd window 10..90, k=4: lower partition first, then rank lands on pivot 50.
    start_win(9);
    do_pass(128, 9, 0, 9, 0, 0, 10, 90, 0, 0);
    do_pass(50, 9, 1, 4, 1, 4, 10, 40, 60, 90);
    wait_result(50, 2);
    ack_result();

    // Seven 200s: single-valued larger partition resolves in one pass.
    start_win(7);
    do_pass(128, 7, 0, 0, 0, 7, 0, 0, 200, 200);
    wait_result(200, 1);
    chk("flat_sel", int'(part_sel), 0);
    ack_result();

    // {1,2,3,4}, k=1: pivots 128, 3, 2.
    start_win(4);
    do_pass(128, 4, 0, 4, 0, 0, 1, 4, 0, 0);
    do_pass(3, 4, 1, 2, 1, 1, 1, 2, 4, 4);
    do_pass(2, 2, 1, 1, 1, 0, 1, 1, 0, 0);
    wait_result(2, 3);
    ack_result();

    // {100,200,210,220}, k=1: rank moves into larger partition and is rebased to 0.
    start_win(4);
    do_pass(128, 4, 0, 1, 0, 3, 100, 100, 200, 220);
    do_pass(210, 3, 2, 1, 1, 1, 200, 200, 220, 220);
    wait_result(200, 2);
    ack_result();

    // Zero-size start is ignored.
    @(negedge clk);
    start = 1'b1; in_size = '0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("zero_size_cs", int'(control_sampled), 0);
      chk("zero_size_send", int'(sending), 1);
      @(negedge clk);
    end

    // Size-1 window {0}.
    start_win(1);
    do_pass(128, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    wait_result(0, 1);
    ack_result();

    // Back-pressure: result held for 20 cycles, a start in DONE is ignored.
    start_win(1);
    do_pass(128, 1, 0, 1, 0, 0, 5, 5, 0, 0);
    wait_result(5, 1);
    for (int i = 0; i < 20; i++) begin
      if (i == 10) begin start = 1'b1; in_size = BSB'(3); end
      if (i == 11) start = 1'b0;
      chk("hold_valid", int'(med_valid), 1);
      chk("hold_median", int'(median), 5);
      chk("hold_send", int'(sending), 1);
      chk("hold_cs", int'(control_sampled), 0);
      @(negedge clk);
    end
    start = 1'b0;
    ack_result();
    repeat (2) begin
      @(negedge clk);
      chk("post_ack_cs", int'(control_sampled), 0);
    end

    // Reset during WAIT_FILL of pass 2.
    start_win(9);
    do_pass(128, 9, 0, 9, 0, 0, 10, 90, 0, 0);
    for (int n = 0; n < 40 && sending; n++) @(negedge clk);
    chk("mid_reset_in_fill", int'(sending), 0);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Normal window after the reset.
    start_win(4);
    do_pass(128, 4, 0, 4, 0, 0, 1, 4, 0, 0);
    do_pass(3, 4, 1, 2, 1, 1, 1, 2, 4, 4);
    do_pass(2, 2, 1, 1, 1, 0, 1, 1, 0, 0);
    wait_result(2, 3);
    ack_result();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
